// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: pops instructions, reads two operands, executes, and pushes results to the result FIFO
module alu_exec_ctrl #(
   parameter int OP_W = 4,
   parameter int RA_W = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            alu_begin,
   input  logic            inst_empty,
   input  logic            inst_rd_ack,
   input  logic            inst_rd_err,
   input  logic [31:0]     inst_dout,
   input  logic            r_full,
   input  logic            r_wr_ack,
   input  logic            r_wr_err,
   input  logic [31:0]     rData,
   output logic            inst_rd_en,
   output logic            r_wr_en,
   output logic            re,
   output logic [RA_W-1:0] rAddr,
   output logic [31:0]     r_din,
   output logic            op_done
);
   typedef enum logic [2:0] {IDLE, POP, WAIT_I, RD_A, RD_B, EXEC, PUSH, WAIT_R} state_t;
   state_t          r_state;
   logic [OP_W-1:0] r_op;
   logic [RA_W-1:0] r_addr_b;
   logic [31:0]     r_op_a, r_op_b;
   logic            r_any, r_begin_q;
   logic [31:0]     w_res;
   logic            w_unused;
   assign w_unused = ^inst_dout[31:12];
   always_comb begin
      w_res = 32'h0;
      case (r_op)
         4'h0: w_res = r_op_a;
         4'h1: w_res = r_op_a + r_op_b;
         4'h2: w_res = r_op_a - r_op_b;
         4'h3: w_res = r_op_a & r_op_b;
         4'h4: w_res = r_op_a | r_op_b;
         4'h5: w_res = r_op_a ^ r_op_b;
         4'h6: w_res = ~r_op_a;
         4'h7: w_res = r_op_a << r_op_b[4:0];
         4'h8: w_res = r_op_a >> r_op_b[4:0];
         4'h9: w_res = $unsigned($signed(r_op_a) >>> r_op_b[4:0]);
         4'hA: w_res = 32'(r_op_a[15:0]) * 32'(r_op_b[15:0]);
         default: w_res = 32'h0;
      endcase
   end
   // r_wr_en is loaded on every entry to PUSH so the strobe appears in the first PUSH cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         inst_rd_en <= 1'b0;
         r_wr_en    <= 1'b0;
         re         <= 1'b0;
         rAddr      <= '0;
         r_din      <= '0;
         op_done    <= 1'b0;
         r_op       <= '0;
         r_addr_b   <= '0;
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_any      <= 1'b0;
         r_begin_q  <= 1'b0;
      end else begin
         r_begin_q <= alu_begin;
         if (alu_begin && !r_begin_q) r_any <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!alu_begin) op_done <= 1'b0;
               else if (!inst_empty) begin
                  op_done    <= 1'b0;
                  inst_rd_en <= 1'b1;
                  r_state    <= POP;
               end else op_done <= r_any && r_begin_q;
            end
            POP: begin
               inst_rd_en <= 1'b0;
               r_state    <= WAIT_I;
            end
            WAIT_I: begin
               if (inst_rd_ack) begin
                  r_op     <= inst_dout[8 +: OP_W];
                  r_addr_b <= inst_dout[0 +: RA_W];
                  rAddr    <= inst_dout[4 +: RA_W];
                  re       <= 1'b1;
                  r_state  <= RD_A;
               end else if (inst_rd_err) r_state <= IDLE;
            end
            RD_A: begin
               r_op_a  <= rData;
               rAddr   <= r_addr_b;
               r_state <= RD_B;
            end
            RD_B: begin
               r_op_b  <= rData;
               re      <= 1'b0;
               r_state <= EXEC;
            end
            EXEC: begin
               r_din   <= w_res;
               r_wr_en <= !r_full;
               r_state <= PUSH;
            end
            PUSH: begin
               if (r_wr_en) begin
                  r_wr_en <= 1'b0;
                  r_state <= WAIT_R;
               end else r_wr_en <= !r_full;
            end
            WAIT_R: begin
               if (r_wr_ack) begin
                  r_any   <= 1'b1;
                  r_state <= IDLE;
               end else if (r_wr_err) begin
                  r_wr_en <= !r_full;
                  r_state <= PUSH;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: FIFO/register-file environment with table, directed and random checks against a reference model
module tb_alu_exec_ctrl;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        alu_begin = 1'b0;
   logic        inst_empty = 1'b1;
   logic        inst_rd_ack = 1'b0;
   logic        inst_rd_err = 1'b0;
   logic [31:0] inst_dout = 32'h0;
   logic        r_full = 1'b0;
   logic        r_wr_ack = 1'b0;
   logic        r_wr_err = 1'b0;
   logic [31:0] rData;
   logic        inst_rd_en, r_wr_en, re, op_done;
   logic [3:0]  rAddr;
   logic [31:0] r_din;
   logic [31:0] regs[16];
   logic [31:0] iq[$];
   logic [31:0] res_q[$];
   logic [31:0] exp_q[$];
   int n_chk = 0, n_fail = 0;
   int cyc = 0, t_pop = 0, t_push = 0;
   int cnt_pop = 0, cnt_push = 0, cnt_re = 0, cnt_wack = 0, werr_n = 0;
   bit pend_i = 0, pend_w = 0, fake_ne = 0;

   alu_exec_ctrl #(.OP_W(4), .RA_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .alu_begin(alu_begin), .inst_empty(inst_empty),
      .inst_rd_ack(inst_rd_ack), .inst_rd_err(inst_rd_err), .inst_dout(inst_dout),
      .r_full(r_full), .r_wr_ack(r_wr_ack), .r_wr_err(r_wr_err), .rData(rData),
      .inst_rd_en(inst_rd_en), .r_wr_en(r_wr_en), .re(re), .rAddr(rAddr),
      .r_din(r_din), .op_done(op_done)
   );

   assign rData = regs[rAddr];

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // FIFO models: acknowledge a strobe on the cycle after it is seen
   initial forever begin
      @(negedge clk);
      inst_rd_ack = 0;
      inst_rd_err = 0;
      r_wr_ack = 0;
      r_wr_err = 0;
      if (pend_i) begin
         if (iq.size() > 0) begin
            inst_dout = iq.pop_front();
            inst_rd_ack = 1;
         end else inst_rd_err = 1;
      end
      if (pend_w) begin
         if (werr_n > 0) begin
            r_wr_err = 1;
            werr_n--;
         end else begin
            r_wr_ack = 1;
            res_q.push_back(r_din);
            cnt_wack++;
         end
      end
      pend_i = inst_rd_en;
      pend_w = r_wr_en;
      if (inst_rd_en) begin cnt_pop++; t_pop = cyc; end
      if (r_wr_en) begin cnt_push++; t_push = cyc; end
      if (re) cnt_re++;
      inst_empty = (iq.size() == 0) && !fake_ne;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] model(int op, logic [31:0] a, logic [31:0] b);
      int s = int'(b % 32);
      longint m = longint'(a % 65536) * longint'(b % 65536);
      if (op == 0) return a;
      if (op == 1) return a + b;
      if (op == 2) return a + ~b + 1;
      if (op == 3) return a & b;
      if (op == 4) return a | b;
      if (op == 5) return a ^ b;
      if (op == 6) return 32'hFFFF_FFFF - a;
      if (op == 7) return a << s;
      if (op == 8) return a >> s;
      if (op == 9) return a[31] ? ~((~a) >> s) : (a >> s);
      if (op == 10) return m[31:0];
      return 32'h0;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic run_batch(int n);
      int w0 = cnt_wack;
      int k = 0;
      alu_begin = 1;
      while (!op_done && k < 2000) begin tick(); k++; end
      chk("done_timeout", 64'(k < 2000), 1);
      chk("acks_before_done", 64'(cnt_wack - w0), 64'(n));
      alu_begin = 0;
      tick();
      tick();
   endtask

   task automatic wait_pop(int p0);
      int k = 0;
      while (cnt_pop == p0 && k < 100) begin tick(); k++; end
      chk("pop_timeout", 64'(k < 100), 1);
   endtask

   task automatic check_results(string name);
      chk({name, "_count"}, 64'(res_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < res_q.size(); i++)
         chk($sformatf("%s_%0d", name, i), res_q[i], exp_q[i]);
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   initial begin
      vec_t tv[3];
      vec_t bv[8];
      int p0, w0, r0;
      logic [31:0] d0, rnd;
      bit bad;
      tv[0] = '{4'h1, 32'd7, 32'd5, 32'd12};
      tv[1] = '{4'h2, 32'd3, 32'd5, 32'hFFFF_FFFE};
      tv[2] = '{4'h9, 32'h8000_0000, 32'd4, 32'hF800_0000};
      bv[0] = '{4'h1, 32'h0000_FFFF, 32'h3, 32'h0001_0002};
      bv[1] = '{4'h2, 32'h0000_FFFF, 32'h3, 32'h0000_FFFC};
      bv[2] = '{4'h3, 32'h0000_FFFF, 32'h3, 32'h0000_0003};
      bv[3] = '{4'h4, 32'h0000_FFFF, 32'h3, 32'h0000_FFFF};
      bv[4] = '{4'h5, 32'h0000_FFFF, 32'h3, 32'h0000_FFFC};
      bv[5] = '{4'h6, 32'h0000_FFFF, 32'h3, 32'hFFFF_0000};
      bv[6] = '{4'h7, 32'h0000_FFFF, 32'h3, 32'h0007_FFF8};
      bv[7] = '{4'hA, 32'h0000_FFFF, 32'h3, 32'h0002_FFFD};
      for (int i = 0; i < 16; i++) regs[i] = 32'h0;
      tick();
      tick();
      chk("reset_outputs", {inst_rd_en, r_wr_en, re, rAddr, r_din, op_done}, 0);
      reset_n = 1;
      tick();

      for (int i = 0; i < 3; i++) begin
         regs[1] = tv[i].a;
         regs[2] = tv[i].b;
         iq.push_back({20'h0, tv[i].op, 8'h12});
         res_q.delete();
         exp_q.delete();
         exp_q.push_back(tv[i].exp);
         p0 = cnt_pop;
         w0 = cnt_push;
         run_batch(1);
         check_results($sformatf("vec%0d", i));
         chk("vec_pops", 64'(cnt_pop - p0), 1);
         chk("vec_pushes", 64'(cnt_push - w0), 1);
         if (i == 0) chk("latency_pop_to_push", 64'(t_push - t_pop), 5);
      end

      regs[1] = 32'h0000_FFFF;
      regs[2] = 32'h0000_0003;
      res_q.delete();
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
         iq.push_back({20'h0, bv[i].op, 8'h12});
         exp_q.push_back(bv[i].exp);
      end
      run_batch(8);
      check_results("batch8");

      // result FIFO full while the result waits in PUSH
      regs[1] = 32'h10;
      regs[2] = 32'h20;
      iq.push_back(32'h0000_0112);
      res_q.delete();
      r_full = 1;
      p0 = cnt_pop;
      w0 = cnt_push;
      alu_begin = 1;
      wait_pop(p0);
      for (int i = 0; i < 6; i++) tick();
      d0 = r_din;
      chk("stall_rdin", d0, 32'h30);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (r_wr_en || r_din !== d0) bad = 1;
      end
      chk("stall_hold", 64'(bad), 0);
      chk("stall_no_push", 64'(cnt_push - w0), 0);
      r_full = 0;
      run_batch(1);
      chk("stall_one_push", 64'(cnt_push - w0), 1);
      chk("stall_result_count", 64'(res_q.size()), 1);
      if (res_q.size() > 0) chk("stall_result", res_q[0], 32'h30);

      iq.push_back(32'h0000_0512);
      res_q.delete();
      exp_q.delete();
      exp_q.push_back(32'h30);
      werr_n = 1;
      w0 = cnt_push;
      run_batch(1);
      chk("retry_pushes", 64'(cnt_push - w0), 2);
      check_results("retry");

      // reset while the second operand is being read
      regs[1] = 32'h1;
      regs[2] = 32'h2;
      iq.push_back(32'h0000_0112);
      res_q.delete();
      p0 = cnt_pop;
      alu_begin = 1;
      wait_pop(p0);
      tick();
      tick();
      tick();
      chk("rdb_re", 64'({re, rAddr}), 64'({1'b1, 4'h2}));
      reset_n = 0;
      #1;
      chk("midreset_outputs", {inst_rd_en, r_wr_en, re, rAddr, r_din, op_done}, 0);
      tick();
      tick();
      reset_n = 1;
      w0 = cnt_push;
      bad = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (op_done || r_wr_en) bad = 1;
      end
      chk("postreset_idle", 64'(bad), 0);
      chk("postreset_no_push", 64'(cnt_push - w0) + 64'(res_q.size()), 0);
      alu_begin = 0;
      tick();

      // pop answered with underflow
      p0 = cnt_pop;
      r0 = cnt_re;
      w0 = cnt_push;
      fake_ne = 1;
      alu_begin = 1;
      wait_pop(p0);
      fake_ne = 0;
      for (int i = 0; i < 10; i++) tick();
      chk("rderr_pops", 64'(cnt_pop - p0), 1);
      chk("rderr_no_reads", 64'(cnt_re - r0), 0);
      chk("rderr_no_push", 64'(cnt_push - w0), 0);
      chk("rderr_no_done", 64'(op_done), 0);
      alu_begin = 0;
      tick();

      for (int b = 0; b < 4; b++) begin
         int a_i, b_i, op;
         res_q.delete();
         exp_q.delete();
         for (int i = 0; i < 16; i++) regs[i] = $urandom();
         regs[3] = 32'h8000_0000 | $urandom();
         for (int i = 0; i < 10; i++) begin
            rnd = $urandom();
            a_i = $urandom_range(15);
            b_i = ($urandom_range(3) == 0) ? a_i : $urandom_range(15);
            op = $urandom_range(15);
            iq.push_back({rnd[31:12], 4'(op), 4'(a_i), 4'(b_i)});
            exp_q.push_back(model(op, regs[a_i], regs[b_i]));
         end
         werr_n = $urandom_range(1);
         run_batch(10);
         check_results($sformatf("rand%0d", b));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
